aes_job_arbiter: RTL and testbench
==================================

Name: aes_job_arbiter

Overview:
- Shares one aes_controller between N_REQ independent requester streams.
- Arbitration is per job: command word through to the tlast block. No interleaving of words from different jobs.
- Records the grant order in a tag FIFO and uses it to route the controller's result stream back to the requester that issued each job.
- Sits between the per-channel DMA/AXIS front ends and the aes_controller input and output buses.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..8.
- DATA_WIDTH, 128: beat width; equals `BLK_S.
- TAG_DEPTH, 8: tag FIFO entries; a power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_tvalid  in  N_REQ  per-requester beat valid
- req_tready  out  N_REQ  per-requester beat ready
- req_tdata  in  N_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_tlast  in  N_REQ  last beat of job
- eng_tvalid  out  1  beat valid to controller
- eng_tready  in  1  controller ready
- eng_tdata  out  DATA_WIDTH  beat to controller
- eng_tlast  out  1  last beat of job to controller
- rsp_in_tvalid  in  1  result beat valid from controller
- rsp_in_tready  out  1  result beat ready to controller
- rsp_in_tdata  in  DATA_WIDTH  result beat from controller
- rsp_in_tlast  in  1  last result beat of job
- rsp_out_tvalid  out  N_REQ  per-requester result valid
- rsp_out_tready  in  N_REQ  per-requester result ready
- rsp_out_tdata  out  DATA_WIDTH  result data, broadcast to all requesters
- rsp_out_tlast  out  1  result last, broadcast to all requesters
- grant_id  out  clog2(N_REQ)  current or last granted requester
- busy  out  1  high while in S_PASS or while the tag FIFO is non-empty

Behaviour:
- Reset state: S_IDLE. The following are all 0 at reset:
  - outputs: req_tready, eng_tvalid, rsp_in_tready, rsp_out_tvalid, busy, grant_id
  - internal: rr_ptr, tag FIFO pointers and count
- Reset mid-job discards the job in flight and all tags. It applies in the same cycle as any other event.

State machine:
- S_IDLE: if any req_tvalid is high and the tag FIFO is not full, go to S_ARB.
- S_ARB (one cycle):
  - Pick the first requester with req_tvalid set, searching from rr_ptr upward with wrap-around modulo N_REQ.
  - Register the winner as grant_id and push it into the tag FIFO.
  - Set rr_ptr to grant_id+1, wrapping N_REQ-1 to 0.
  - Go to S_PASS.
  - If no request is still valid, return to S_IDLE with no push.
- S_PASS: combinational pass-through of the granted requester only.
  - eng_tvalid = req_tvalid[g]
  - eng_tdata = requester g's slice
  - eng_tlast = req_tlast[g]
  - req_tready[g] = eng_tready; all other req_tready bits are 0.
  - On an accepted beat with eng_tlast=1: go to S_IDLE, or go directly to S_ARB if another request is pending and the tag FIFO is not full.

Handshake rules:
- eng_tvalid must not depend on eng_tready.
- Once asserted, eng_tvalid and eng_tdata stay stable until accepted, because requesters obey AXIS rules.
- Minimum gap between jobs: 1 cycle (S_ARB).
- Tag FIFO full: no arbitration; the current S_PASS job completes normally.

Response routing (independent of the arbitration FSM):
- h = head of the tag FIFO.
- rsp_out_tvalid[h] = rsp_in_tvalid when the FIFO is non-empty; all other rsp_out_tvalid bits are 0.
- rsp_in_tready = rsp_out_tready[h] when the FIFO is non-empty, else 0.
- rsp_out_tdata and rsp_out_tlast are wired straight from rsp_in_tdata and rsp_in_tlast.
- Pop the FIFO on an accepted response beat with rsp_in_tlast=1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo TAG_DEPTH.

Optional Feature:
- Macro: AES_ARB_CH0_PRIO_EN.
- Defined: requester 0 wins every S_ARB in which req_tvalid[0]=1, regardless of rr_ptr. rr_ptr is left unchanged when requester 0 wins. Other requesters follow round-robin among themselves. Priority is applied at job boundaries only; it never preempts a job in S_PASS.
- Undefined: pure round-robin over all requesters.

Test Plan:
- Single requester 2 sends a 3-beat job (cmd, key, blk with tlast); controller returns 1 beat with tlast.
  -> eng sees 3 beats in order with grant_id=2.
  -> Response appears only on rsp_out_tvalid[2].
  -> Tag count goes 0->1->0.
- All 4 requesters hold valid continuously, each job 2 beats.
  -> Grant order 0,1,2,3,0.
  -> No interleaving: eng_tlast occurs exactly every 2 accepted beats.
- TAG_DEPTH=2, controller withholds responses.
  -> After 2 jobs no further S_ARB occurs, and req_tready stays 0 for requester 3.
  -> Releasing one response re-enables arbitration within 2 cycles.
- eng_tready toggles 1,0,0,1 during a job.
  -> eng_tdata held stable while eng_tvalid=1 and eng_tready=0.
  -> No beat lost or duplicated.
- reset asserted in the middle of beat 2 of a 4-beat job.
  -> Next cycle: all outputs are 0, tag FIFO is empty, state is S_IDLE.
  -> A fresh job from requester 1 is then granted normally.
- With AES_ARB_CH0_PRIO_EN defined, requesters 0 and 3 request continuously.
  -> Every grant goes to 0.
  -> Once requester 0 deasserts, requester 3 is granted in the next S_ARB.

Source files
------------

// File: rtl/aes_job_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_job_arbiter_if
// Brief    : Requester, engine and response stream bundle for aes_job_arbiter.
// Revision : 1.0
// ============================================================================
interface aes_job_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 128
);
    logic [N_REQ-1:0]            req_tvalid;
    logic [N_REQ-1:0]            req_tready;
    logic [N_REQ*DATA_WIDTH-1:0] req_tdata;
    logic [N_REQ-1:0]            req_tlast;

    logic                        eng_tvalid;
    logic                        eng_tready;
    logic [DATA_WIDTH-1:0]       eng_tdata;
    logic                        eng_tlast;

    logic                        rsp_in_tvalid;
    logic                        rsp_in_tready;
    logic [DATA_WIDTH-1:0]       rsp_in_tdata;
    logic                        rsp_in_tlast;

    logic [N_REQ-1:0]            rsp_out_tvalid;
    logic [N_REQ-1:0]            rsp_out_tready;
    logic [DATA_WIDTH-1:0]       rsp_out_tdata;
    logic                        rsp_out_tlast;

    // Arbiter side
    modport slave (
        input  req_tvalid, req_tdata, req_tlast, eng_tready,
               rsp_in_tvalid, rsp_in_tdata, rsp_in_tlast, rsp_out_tready,
        output req_tready, eng_tvalid, eng_tdata, eng_tlast,
               rsp_in_tready, rsp_out_tvalid, rsp_out_tdata, rsp_out_tlast
    );

    // Requester / engine side
    modport master (
        output req_tvalid, req_tdata, req_tlast, eng_tready,
               rsp_in_tvalid, rsp_in_tdata, rsp_in_tlast, rsp_out_tready,
        input  req_tready, eng_tvalid, eng_tdata, eng_tlast,
               rsp_in_tready, rsp_out_tvalid, rsp_out_tdata, rsp_out_tlast
    );
endinterface
`default_nettype wire

// File: rtl/aes_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_job_arbiter
// Brief    : Per-job round-robin arbiter sharing one AES controller among
//            N_REQ streams; a tag FIFO routes results back in grant order.
//            Optional macro AES_ARB_CH0_PRIO_EN gives requester 0 priority.
// Revision : 1.0
// ============================================================================
module aes_job_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_DEPTH  = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    aes_job_arbiter_if.slave       bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                   busy
);
    localparam int c_GW = $clog2(N_REQ);
    localparam int c_AW = $clog2(TAG_DEPTH);
    localparam int c_CW = c_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_PASS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_GW-1:0]   r_grant;
    logic [c_GW-1:0]   r_rr_ptr;
    logic [c_GW-1:0]   w_winner;
    logic [c_GW-1:0]   w_rr_nxt;
    logic              w_found;
    logic              w_prio_win;
    logic [N_REQ-1:0]  w_others;

    logic [c_GW-1:0]   r_tag_mem [TAG_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [c_GW-1:0]   w_head;

    assign w_full   = (r_count == c_CW'(TAG_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_head   = r_tag_mem[r_rd_ptr];
    assign w_others = bus.req_tvalid & ~(N_REQ'(1) << r_grant);
    assign w_rr_nxt = (w_winner == c_GW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;

    // Winner search starting at rr_ptr; with priority enabled, requester 0
    // short-circuits the search and leaves rr_ptr untouched.
    always_comb begin : p_arb_search
        int idx;
        w_found    = 1'b0;
        w_winner   = '0;
        w_prio_win = 1'b0;
`ifdef AES_ARB_CH0_PRIO_EN
        w_prio_win = bus.req_tvalid[0];
`endif
        if (w_prio_win) begin
            w_found  = 1'b1;
            w_winner = '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                if (!w_found && bus.req_tvalid[c_GW'(idx)]) begin
                    w_found  = 1'b1;
                    w_winner = c_GW'(idx);
                end
            end
        end
    end

    always_comb begin : p_fsm_comb
        w_state_nxt    = r_state;
        w_push         = 1'b0;
        bus.req_tready = '0;
        bus.eng_tvalid = 1'b0;
        bus.eng_tdata  = '0;
        bus.eng_tlast  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((|bus.req_tvalid) && !w_full) begin
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (w_found) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_PASS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PASS: begin
                bus.eng_tvalid          = bus.req_tvalid[r_grant];
                bus.eng_tdata           = bus.req_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
                bus.eng_tlast           = bus.req_tlast[r_grant];
                bus.req_tready[r_grant] = bus.eng_tready;
                if (bus.req_tvalid[r_grant] && bus.eng_tready && bus.req_tlast[r_grant]) begin
                    w_state_nxt = ((|w_others) && !w_full) ? S_ARB : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_grant  <= w_winner;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (!w_prio_win) begin
                    r_rr_ptr <= w_rr_nxt;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_winner;
        end
    end

    // Result routing follows the FIFO head, independent of the FSM.
    always_comb begin : p_rsp_route
        bus.rsp_out_tvalid = '0;
        bus.rsp_in_tready  = 1'b0;
        if (!w_empty) begin
            bus.rsp_out_tvalid[w_head] = bus.rsp_in_tvalid;
            bus.rsp_in_tready          = bus.rsp_out_tready[w_head];
        end
    end

    assign w_pop             = bus.rsp_in_tvalid && bus.rsp_in_tready && bus.rsp_in_tlast;
    assign bus.rsp_out_tdata = bus.rsp_in_tdata;
    assign bus.rsp_out_tlast = bus.rsp_in_tlast;
    assign grant_id          = r_grant;
    assign busy              = (r_state == S_PASS) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_aes_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_job_arbiter
// Brief    : Directed self-checking bench for aes_job_arbiter (N_REQ=4,
//            TAG_DEPTH=2); expectations follow AES_ARB_CH0_PRIO_EN if defined.
// Revision : 1.0
// ============================================================================
module tb_aes_job_arbiter;
    localparam int NR = 4;
    localparam int DW = 128;

    logic        clk;
    logic        reset;
    logic [1:0]  grant_id;
    logic        busy;

    aes_job_arbiter_if #(.N_REQ(NR), .DATA_WIDTH(DW)) bus ();

    aes_job_arbiter #(.N_REQ(NR), .DATA_WIDTH(DW), .TAG_DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int rem  [NR];
    int blen [NR];
    int cnt  [NR];
    int grants   [$];
    int jobbeats [$];
    bit seen_rdy3;
    int exp_ord [5];
    int exp3;

    function automatic logic [DW-1:0] dat(input int r, input int b);
        return {64'hFACE_0000_0000_0000 | 64'(r), 64'hB000_0000_0000_0000 | 64'(b)};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        bus.req_tvalid     = '0;
        bus.req_tdata      = '0;
        bus.req_tlast      = '0;
        bus.eng_tready     = 1'b0;
        bus.rsp_in_tvalid  = 1'b0;
        bus.rsp_in_tdata   = '0;
        bus.rsp_in_tlast   = 1'b0;
        bus.rsp_out_tready = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; blen[i] = 1; cnt[i] = 0;
        end
        grants.delete();
        jobbeats.delete();
        seen_rdy3 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [DW-1:0] d, input logic last);
        bus.req_tvalid[r]          = 1'b1;
        bus.req_tdata[r*DW +: DW]  = d;
        bus.req_tlast[r]           = last;
    endtask

    // AXIS source model for every requester plus an engine-side beat logger.
    task automatic run(input int cycles, input int stop_jobs);
        int nb;
        nb = 0;
        for (int c = 0; c < cycles && grants.size() < stop_jobs; c++) begin
            for (int i = 0; i < NR; i++) begin
                bus.req_tvalid[i]         = (rem[i] > 0);
                bus.req_tdata[i*DW +: DW] = dat(i, cnt[i]);
                bus.req_tlast[i]          = (cnt[i] == blen[i] - 1);
            end
            #1;
            if (bus.req_tready[3]) seen_rdy3 = 1'b1;
            if (bus.eng_tvalid && bus.eng_tready) begin
                chk("run_beat_data", bus.eng_tdata, dat(int'(grant_id), cnt[grant_id]));
                nb++;
                if (bus.eng_tlast) begin
                    grants.push_back(int'(grant_id));
                    jobbeats.push_back(nb);
                    nb = 0;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_tvalid[i] && bus.req_tready[i]) begin
                    if (cnt[i] == blen[i] - 1) begin
                        cnt[i] = 0;
                        rem[i]--;
                    end else begin
                        cnt[i]++;
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        reset = 1'b1;
        tick();
        chk("rst_req_tready", 128'(bus.req_tready), 128'(0));
        chk("rst_eng_tvalid", 128'(bus.eng_tvalid), 128'(0));
        chk("rst_rsp_in_tready", 128'(bus.rsp_in_tready), 128'(0));
        chk("rst_rsp_out_tvalid", 128'(bus.rsp_out_tvalid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_grant_id", 128'(grant_id), 128'(0));
        chk("rst_tag_count", 128'(dut.r_count), 128'(0));
        reset = 1'b0;

        // Single requester 2, 3-beat job, one result beat
        bus.eng_tready = 1'b1;
        set_req(2, dat(2, 0), 1'b0);
        #1 chk("t1_idle_eng_tvalid", 128'(bus.eng_tvalid), 128'(0));
        tick();
        #1 chk("t1_arb_req_tready", 128'(bus.req_tready), 128'(0));
        tick();
        #1;
        chk("t1_pass_eng_tvalid", 128'(bus.eng_tvalid), 128'(1));
        chk("t1_beat0", bus.eng_tdata, dat(2, 0));
        chk("t1_req_tready", 128'(bus.req_tready), 128'(4'b0100));
        chk("t1_grant_id", 128'(grant_id), 128'(2));
        chk("t1_tag_count_1", 128'(dut.r_count), 128'(1));
        tick();
        set_req(2, dat(2, 1), 1'b0);
        #1 chk("t1_beat1", bus.eng_tdata, dat(2, 1));
        tick();
        set_req(2, dat(2, 2), 1'b1);
        #1;
        chk("t1_beat2", bus.eng_tdata, dat(2, 2));
        chk("t1_eng_tlast", 128'(bus.eng_tlast), 128'(1));
        tick();
        bus.req_tvalid = '0;
        bus.req_tlast  = '0;
        #1;
        chk("t1_done_eng_tvalid", 128'(bus.eng_tvalid), 128'(0));
        chk("t1_busy_pending", 128'(busy), 128'(1));
        bus.rsp_in_tvalid  = 1'b1;
        bus.rsp_in_tlast   = 1'b1;
        bus.rsp_in_tdata   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        bus.rsp_out_tready = 4'hF;
        #1;
        chk("t1_rsp_route", 128'(bus.rsp_out_tvalid), 128'(4'b0100));
        chk("t1_rsp_data", bus.rsp_out_tdata, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
        chk("t1_rsp_in_tready", 128'(bus.rsp_in_tready), 128'(1));
        tick();
        bus.rsp_in_tvalid = 1'b0;
        #1;
        chk("t1_tag_count_0", 128'(dut.r_count), 128'(0));
        chk("t1_busy_clear", 128'(busy), 128'(0));

        // All requesters continuous, 2-beat jobs, results drained at once
        do_reset();
`ifdef AES_ARB_CH0_PRIO_EN
        exp_ord = '{0, 0, 1, 2, 3};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < NR; i++) begin
            rem[i] = 2; blen[i] = 2;
        end
        bus.eng_tready     = 1'b1;
        bus.rsp_in_tvalid  = 1'b1;
        bus.rsp_in_tlast   = 1'b1;
        bus.rsp_out_tready = 4'hF;
        run(60, 5);
        chk("t2_job_count", 128'(grants.size()), 128'(5));
        for (int k = 0; k < 5 && k < grants.size(); k++) begin
            chk("t2_grant_order", 128'(grants[k]), 128'(exp_ord[k]));
            chk("t2_beats_per_job", 128'(jobbeats[k]), 128'(2));
        end

        // Tag FIFO full with responses withheld
        do_reset();
        for (int i = 0; i < NR; i++) begin
            rem[i] = 5; blen[i] = 1;
        end
        bus.eng_tready = 1'b1;
        run(14, 99);
        chk("t3_jobs_before_full", 128'(grants.size()), 128'(2));
        chk("t3_req3_never_ready", 128'(seen_rdy3), 128'(0));
        chk("t3_tag_count_full", 128'(dut.r_count), 128'(2));
        bus.rsp_in_tvalid  = 1'b1;
        bus.rsp_in_tlast   = 1'b1;
        bus.rsp_out_tready = 4'hF;
        #1;
        chk("t3_release_route", 128'(bus.rsp_out_tvalid), 128'(4'b0001));
        tick();
        bus.rsp_in_tvalid = 1'b0;
`ifdef AES_ARB_CH0_PRIO_EN
        exp3 = 0;
`else
        exp3 = 2;
`endif
        run(3, 3);
        chk("t3_rearb_in_time", 128'(grants.size()), 128'(3));
        if (grants.size() == 3) chk("t3_rearb_grant", 128'(grants[2]), 128'(exp3));

        // eng_tready toggles 1,0,0,1 inside a 3-beat job from requester 1
        do_reset();
        bus.eng_tready = 1'b1;
        set_req(1, dat(1, 0), 1'b0);
        tick();
        tick();
        #1 chk("t4_beat0", bus.eng_tdata, dat(1, 0));
        tick();
        set_req(1, dat(1, 1), 1'b0);
        bus.eng_tready = 1'b0;
        #1;
        chk("t4_beat1_offered", bus.eng_tdata, dat(1, 1));
        chk("t4_stall_ready", 128'(bus.req_tready), 128'(0));
        tick();
        #1;
        chk("t4_hold_valid", 128'(bus.eng_tvalid), 128'(1));
        chk("t4_hold_data", bus.eng_tdata, dat(1, 1));
        tick();
        bus.eng_tready = 1'b1;
        #1;
        chk("t4_resume_data", bus.eng_tdata, dat(1, 1));
        chk("t4_resume_ready", 128'(bus.req_tready), 128'(4'b0010));
        tick();
        set_req(1, dat(1, 2), 1'b1);
        #1;
        chk("t4_beat2", bus.eng_tdata, dat(1, 2));
        chk("t4_tlast", 128'(bus.eng_tlast), 128'(1));
        tick();
        bus.req_tvalid = '0;
        bus.req_tlast  = '0;
        #1 chk("t4_no_extra_beat", 128'(bus.eng_tvalid), 128'(0));

        // Reset during the second beat of a 4-beat job
        do_reset();
        bus.eng_tready = 1'b1;
        set_req(0, dat(0, 0), 1'b0);
        tick();
        tick();
        tick();
        set_req(0, dat(0, 1), 1'b0);
        bus.rsp_in_tvalid  = 1'b1;
        bus.rsp_out_tready = 4'hF;
        #1 chk("t5_mid_job_data", bus.eng_tdata, dat(0, 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_tvalid = '0;
        #1;
        chk("t5_req_tready", 128'(bus.req_tready), 128'(0));
        chk("t5_eng_tvalid", 128'(bus.eng_tvalid), 128'(0));
        chk("t5_rsp_in_tready", 128'(bus.rsp_in_tready), 128'(0));
        chk("t5_rsp_out_tvalid", 128'(bus.rsp_out_tvalid), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_grant_id", 128'(grant_id), 128'(0));
        chk("t5_tag_count", 128'(dut.r_count), 128'(0));
        chk("t5_state_idle", 128'(dut.r_state), 128'(0));
        bus.rsp_in_tvalid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; blen[i] = 1; cnt[i] = 0;
        end
        rem[1] = 1;
        run(6, 1);
        chk("t5_fresh_job", 128'(grants.size()), 128'(1));
        if (grants.size() == 1) chk("t5_fresh_grant", 128'(grants[0]), 128'(1));

        // Requesters 0 and 3 competing; requester 0 runs out after 4 jobs
        do_reset();
`ifdef AES_ARB_CH0_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 3};
`else
        exp_ord = '{0, 3, 0, 3, 0};
`endif
        rem[0] = 4;
        rem[3] = 6;
        bus.eng_tready     = 1'b1;
        bus.rsp_in_tvalid  = 1'b1;
        bus.rsp_in_tlast   = 1'b1;
        bus.rsp_out_tready = 4'hF;
        run(60, 5);
        chk("t6_job_count", 128'(grants.size()), 128'(5));
        for (int k = 0; k < 5 && k < grants.size(); k++) begin
            chk("t6_grant_order", 128'(grants[k]), 128'(exp_ord[k]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
